// File: rtl/cache_tag_lookup.sv
// N-way set-associative tag store: registered hit/dirty lookup, victim
// selection (lowest invalid way, else tree pseudo-LRU) and fill/invalidate.
module cache_tag_lookup #(
  parameter  int TAG_W = 9,
  parameter  int IDX_W = 3,
  parameter  int WAYS  = 2,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_write,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             fill_dirty,
  input  logic             inval_valid,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output logic             resp_dirty,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_valid,
  output logic             victim_dirty,
  output logic [TAG_W-1:0] victim_tag
);

  localparam int SETS = 2 ** IDX_W;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAYS-2:0]  plru_q  [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];

  // Walk the heap-ordered tree from the root; each node bit picks a half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] p);
    int               node;
    logic [WAY_W-1:0] w;
    node = 0;
    w    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      w    = (w << 1) | WAY_W'(p[node]);
      node = 2 * node + 1 + int'(p[node]);
    end
    return w;
  endfunction

  // Point every node on the path to way w away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p,
                                                 input logic [WAY_W-1:0] w);
    int              node;
    logic            b;
    logic [WAYS-2:0] q;
    q    = p;
    node = 0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      b       = w[l];
      q[node] = ~b;
      node    = 2 * node + 1 + int'(b);
    end
    return q;
  endfunction

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    // Scanning downward leaves the lowest matching / invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim = inv_found ? inv_way : plru_victim(plru_q[req_index]);
  end

  // NOTE: non-blocking assignments throughout sequential logic; the later
  // assignment in program order wins, which gives fill its precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (req_valid && hit) begin
        plru_q[req_index] <= plru_touch(plru_q[req_index], hit_way);
        if (req_write) dirty_q[req_index][hit_way] <= 1'b1;
      end
      if (fill_valid) begin
        valid_q[fill_index][fill_way] <= 1'b1;
        dirty_q[fill_index][fill_way] <= fill_dirty;
        plru_q[fill_index]            <= plru_touch(plru_q[fill_index], fill_way);
      end else if (inval_valid) begin
        valid_q[fill_index][fill_way] <= 1'b0;
        dirty_q[fill_index][fill_way] <= 1'b0;
      end
    end
  end

  // NOTE: tag storage is deliberately not reset; valid=0 makes stale tags harmless.
  always_ff @(posedge clk) begin
    if (fill_valid) tag_q[fill_index][fill_way] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_way     <= '0;
      resp_dirty   <= 1'b0;
      victim_way   <= '0;
      victim_valid <= 1'b0;
      victim_dirty <= 1'b0;
      victim_tag   <= '0;
    end else begin
      resp_valid <= req_valid;
      if (req_valid) begin
        resp_hit     <= hit;
        resp_way     <= hit_way;
        resp_dirty   <= hit & dirty_q[req_index][hit_way];
        victim_way   <= victim;
        victim_valid <= valid_q[req_index][victim];
        victim_dirty <= valid_q[req_index][victim] & dirty_q[req_index][victim];
        victim_tag   <= tag_q[req_index][victim];
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup: a 2-way and a 4-way instance share one
// stimulus stream; each table row is one cycle with its expected response.
module tb_cache_tag_lookup;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_write, fill_valid, fill_dirty, inval_valid;
  logic [2:0] req_index, fill_index;
  logic [8:0] req_tag, fill_tag;
  logic [1:0] fill_way;
  logic       fill_way2;

  logic       a_resp_valid, a_hit, a_way, a_dirty, a_vway, a_vval, a_vdirty;
  logic [8:0] a_vtag;
  logic       b_resp_valid, b_hit, b_dirty, b_vval, b_vdirty;
  logic [1:0] b_way, b_vway;
  logic [8:0] b_vtag;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign fill_way2 = fill_way[0];

  always #5 clk = ~clk;

  cache_tag_lookup #(.TAG_W(9), .IDX_W(3), .WAYS(2)) u_way2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_index(req_index), .req_tag(req_tag), .req_write(req_write),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way2),
    .fill_tag(fill_tag), .fill_dirty(fill_dirty), .inval_valid(inval_valid),
    .resp_valid(a_resp_valid), .resp_hit(a_hit), .resp_way(a_way), .resp_dirty(a_dirty),
    .victim_way(a_vway), .victim_valid(a_vval), .victim_dirty(a_vdirty), .victim_tag(a_vtag)
  );

  cache_tag_lookup #(.TAG_W(9), .IDX_W(3), .WAYS(4)) u_way4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_index(req_index), .req_tag(req_tag), .req_write(req_write),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_dirty(fill_dirty), .inval_valid(inval_valid),
    .resp_valid(b_resp_valid), .resp_hit(b_hit), .resp_way(b_way), .resp_dirty(b_dirty),
    .victim_way(b_vway), .victim_valid(b_vval), .victim_dirty(b_vdirty), .victim_tag(b_vtag)
  );

  typedef struct {
    logic       rv;  logic [2:0] ri; logic [8:0] rt; logic rw;
    logic       fv;  logic [2:0] fi; logic [1:0] fw; logic [8:0] ft; logic fd; logic iv;
    logic       d4;  // compare the 4-way instance instead of the 2-way one
    logic       ck;  // compare the response fields
    logic       hit; logic [1:0] way; logic dirty;
    logic [1:0] vway; logic vval; logic vdirty; logic [8:0] vtag;
  } vec_t;

  function automatic vec_t mk(int rv, int ri, int rt, int rw,
                              int fv, int fi, int fw, int ft, int fd, int iv,
                              int d4, int ck,
                              int hit, int way, int dirty,
                              int vway, int vval, int vdirty, int vtag);
    vec_t v;
    v.rv = rv[0];   v.ri = ri[2:0]; v.rt = rt[8:0]; v.rw = rw[0];
    v.fv = fv[0];   v.fi = fi[2:0]; v.fw = fw[1:0]; v.ft = ft[8:0];
    v.fd = fd[0];   v.iv = iv[0];   v.d4 = d4[0];   v.ck = ck[0];
    v.hit = hit[0]; v.way = way[1:0]; v.dirty = dirty[0];
    v.vway = vway[1:0]; v.vval = vval[0]; v.vdirty = vdirty[0]; v.vtag = vtag[8:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic run(input vec_t v, input string id);
    logic [31:0] hit, way, dirty, vway, vval, vdirty, vtag;
    @(negedge clk);
    req_valid  = v.rv; req_index  = v.ri; req_tag  = v.rt; req_write  = v.rw;
    fill_valid = v.fv; fill_index = v.fi; fill_way = v.fw; fill_tag   = v.ft;
    fill_dirty = v.fd; inval_valid = v.iv;
    @(posedge clk);
    #1;
    check({id, " resp_valid w2"}, 32'(a_resp_valid), 32'(v.rv));
    check({id, " resp_valid w4"}, 32'(b_resp_valid), 32'(v.rv));
    if (v.ck) begin
      hit    = v.d4 ? 32'(b_hit)    : 32'(a_hit);
      way    = v.d4 ? 32'(b_way)    : 32'(a_way);
      dirty  = v.d4 ? 32'(b_dirty)  : 32'(a_dirty);
      vway   = v.d4 ? 32'(b_vway)   : 32'(a_vway);
      vval   = v.d4 ? 32'(b_vval)   : 32'(a_vval);
      vdirty = v.d4 ? 32'(b_vdirty) : 32'(a_vdirty);
      vtag   = v.d4 ? 32'(b_vtag)   : 32'(a_vtag);
      check({id, " resp_hit"},     hit,    32'(v.hit));
      check({id, " resp_way"},     way,    32'(v.way));
      check({id, " resp_dirty"},   dirty,  32'(v.dirty));
      check({id, " victim_way"},   vway,   32'(v.vway));
      check({id, " victim_valid"}, vval,   32'(v.vval));
      check({id, " victim_dirty"}, vdirty, 32'(v.vdirty));
      if (v.vval) check({id, " victim_tag"}, vtag, 32'(v.vtag));
    end
  endtask

  vec_t tbl [26];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             rv ri rt    rw  fv fi fw ft   fd iv  d4 ck  hit way dty  vw vv vd vtag
    tbl[0]  = mk(1, 3, 'h1A5, 0,  0, 0, 0, 0,    0, 0,  0, 1,  0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,     0,  0, 0, 0, 0,    0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,     0,  1, 3, 0, 'h1A5,0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0);
    tbl[3]  = mk(1, 3, 'h1A5, 0,  0, 0, 0, 0,    0, 0,  0, 1,  1, 0, 0,  1, 0, 0, 0);
    tbl[4]  = mk(1, 3, 'h1A5, 1,  0, 0, 0, 0,    0, 0,  0, 1,  1, 0, 0,  1, 0, 0, 0);
    tbl[5]  = mk(1, 3, 'h1A5, 0,  0, 0, 0, 0,    0, 0,  0, 1,  1, 0, 1,  1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,     0,  1, 3, 1, 'h0F0,1, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0);
    tbl[7]  = mk(1, 3, 'h1A5, 0,  0, 0, 0, 0,    0, 0,  0, 1,  1, 0, 1,  0, 1, 1, 'h1A5);
    tbl[8]  = mk(1, 3, 'h077, 0,  0, 0, 0, 0,    0, 0,  0, 1,  0, 0, 0,  1, 1, 1, 'h0F0);
    tbl[9]  = mk(0, 0, 0,     0,  1, 5, 0, 'h100,0, 0,  1, 0,  0, 0, 0,  0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,     0,  1, 5, 1, 'h101,0, 0,  1, 0,  0, 0, 0,  0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0,     0,  1, 5, 2, 'h102,0, 0,  1, 0,  0, 0, 0,  0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0,     0,  1, 5, 3, 'h103,0, 0,  1, 0,  0, 0, 0,  0, 0, 0, 0);
    // Touch order 2,0,1 leaves the tree pointing at way 3; touching 3 moves it to 0.
    tbl[13] = mk(1, 5, 'h102, 0,  0, 0, 0, 0,    0, 0,  1, 1,  1, 2, 0,  0, 1, 0, 'h100);
    tbl[14] = mk(1, 5, 'h100, 0,  0, 0, 0, 0,    0, 0,  1, 1,  1, 0, 0,  0, 1, 0, 'h100);
    tbl[15] = mk(1, 5, 'h101, 0,  0, 0, 0, 0,    0, 0,  1, 1,  1, 1, 0,  3, 1, 0, 'h103);
    tbl[16] = mk(1, 5, 'h103, 0,  0, 0, 0, 0,    0, 0,  1, 1,  1, 3, 0,  3, 1, 0, 'h103);
    tbl[17] = mk(1, 5, 'h1FF, 0,  0, 0, 0, 0,    0, 0,  1, 1,  0, 0, 0,  0, 1, 0, 'h100);
    tbl[18] = mk(1, 2, 'h0AA, 0,  1, 2, 0, 'h0AA,0, 0,  0, 1,  0, 0, 0,  0, 0, 0, 0);
    tbl[19] = mk(1, 2, 'h0AA, 0,  0, 0, 0, 0,    0, 0,  0, 1,  1, 0, 0,  1, 0, 0, 0);
    tbl[20] = mk(1, 2, 'h0AA, 1,  1, 2, 0, 'h0AA,0, 0,  0, 1,  1, 0, 0,  1, 0, 0, 0);
    tbl[21] = mk(1, 2, 'h0AA, 0,  0, 0, 0, 0,    0, 0,  0, 1,  1, 0, 0,  1, 0, 0, 0);
    tbl[22] = mk(0, 0, 0,     0,  1, 2, 1, 'h0BB,1, 1,  0, 0,  0, 0, 0,  0, 0, 0, 0);
    tbl[23] = mk(1, 2, 'h0BB, 0,  0, 0, 0, 0,    0, 0,  0, 1,  1, 1, 1,  0, 1, 0, 'h0AA);
    tbl[24] = mk(0, 0, 0,     0,  0, 2, 1, 0,    0, 1,  0, 0,  0, 0, 0,  0, 0, 0, 0);
    tbl[25] = mk(1, 2, 'h0BB, 0,  0, 0, 0, 0,    0, 0,  0, 1,  0, 0, 0,  1, 0, 0, 0);

    rst = 1'b1;
    req_valid = 1'b0; req_index = '0; req_tag = '0; req_write = 1'b0;
    fill_valid = 1'b0; fill_index = '0; fill_way = '0; fill_tag = '0;
    fill_dirty = 1'b0; inval_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset resp_valid w2", 32'(a_resp_valid), 32'd0);
    check("reset resp_valid w4", 32'(b_resp_valid), 32'd0);
    check("reset resp_hit",      32'(a_hit),        32'd0);
    check("reset resp_way",      32'(a_way),        32'd0);
    check("reset resp_dirty",    32'(a_dirty),      32'd0);
    check("reset victim_way",    32'(a_vway),       32'd0);
    check("reset victim_valid",  32'(a_vval),       32'd0);
    check("reset victim_dirty",  32'(a_vdirty),     32'd0);
    check("reset victim_tag",    32'(a_vtag),       32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) run(tbl[i], $sformatf("row%0d", i));

    // Reset coinciding with a request discards it; state is cleared afterwards.
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_index = 3'd3; req_tag = 9'h1A5; req_write = 1'b0;
    fill_valid = 1'b0; inval_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst+req resp_valid w2", 32'(a_resp_valid), 32'd0);
    check("rst+req resp_valid w4", 32'(b_resp_valid), 32'd0);
    check("rst+req victim_dirty",  32'(a_vdirty),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    run(mk(1, 3, 'h1A5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "post_rst w2");
    run(mk(1, 5, 'h100, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "post_rst w4");
    run(mk(1, 3, 'h0F0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "post_rst w4 idx3");
    run(mk(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst idle");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
